// File: rtl/conv_mac_sequencer_pkg.sv
// Shared types and default widths for the convolution MAC sequencer.
//   state_e      : sequencer FSM states
//   Def*         : default parameter values used by the top, sub-module and interface
package conv_mac_sequencer_pkg;

    localparam int unsigned DefDataW  = 8;
    localparam int unsigned DefAccW   = 32;
    localparam int unsigned DefAddrW  = 8;
    localparam int unsigned DefTapW   = 5;
    localparam int unsigned DefMacLat = 1;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFetch,
        StDrain,
        StHold
    } state_e;

endpackage

// File: rtl/conv_mac_sequencer_if.sv
// Result stream between the sequencer and its consumer (valid/ready).
//   data  : captured accumulator sum for the current output index
//   valid : data valid, held until ready
//   ready : consumer accepts data
interface conv_mac_sequencer_if
    import conv_mac_sequencer_pkg::*;
#(
    parameter int unsigned AccW = DefAccW
);
    logic [AccW-1:0] data;
    logic            valid;
    logic            ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/conv_mac_sequencer_addr_gen.sv
// Address generator for the convolution sequencer.
// Holds the latched configuration plus the output index n and tap index k.
//   clk, rst_n        : clock, async active-low reset
//   load              : latch base/taps/outs and clear n, k
//   base, taps, outs  : configuration sampled on load
//   tap_step          : advance k (wraps to 0 after the last tap)
//   out_step          : advance n
//   sample_addr       : base + n + k, wrapping modulo 2**AddrW
//   coef_addr         : k
//   last_tap/last_out : k / n at their final value
module conv_mac_sequencer_addr_gen
    import conv_mac_sequencer_pkg::*;
#(
    parameter int unsigned AddrW = DefAddrW,
    parameter int unsigned TapW  = DefTapW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [AddrW-1:0] base,
    input  logic [TapW-1:0]  taps,
    input  logic [AddrW-1:0] outs,
    input  logic             tap_step,
    input  logic             out_step,
    output logic [AddrW-1:0] sample_addr,
    output logic [TapW-1:0]  coef_addr,
    output logic             last_tap,
    output logic             last_out
);

    logic [AddrW-1:0] base_q;
    logic [TapW-1:0]  taps_q;
    logic [AddrW-1:0] outs_q;
    logic [AddrW-1:0] n_q;
    logic [TapW-1:0]  k_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            taps_q <= '0;
            outs_q <= '0;
            n_q    <= '0;
            k_q    <= '0;
        end else if (load) begin
            base_q <= base;
            taps_q <= taps;
            outs_q <= outs;
            n_q    <= '0;
            k_q    <= '0;
        end else begin
            // k returns to 0 after the last tap so the next output starts clean
            if (tap_step) begin
                k_q <= last_tap ? '0 : k_q + TapW'(1);
            end
            if (out_step) begin
                n_q <= n_q + AddrW'(1);
            end
        end
    end

    assign sample_addr = base_q + n_q + AddrW'(k_q);
    assign coef_addr   = k_q;
    assign last_tap    = (k_q == taps_q - TapW'(1));
    assign last_out    = (n_q == outs_q - AddrW'(1));

endmodule

// File: rtl/conv_mac_sequencer.sv
// Sequences one shared signed MAC to compute a 1-D valid convolution:
//   result[n] = sum_k coef[k] * sample[sample_base + n + k]
// Ports:
//   clk, rst_n                   : clock, async active-low reset
//   start                        : 1-cycle request, accepted only when idle
//   sample_base/num_taps/num_out : configuration, latched on accepted start
//   sample_addr/sample_data      : sample RAM (1-cycle read latency)
//   coef_addr/coef_data          : coefficient RAM (1-cycle read latency)
//   mac_x, mac_y                 : registered MAC operands, 0 when no tap is in flight
//   accum_reset                  : synchronous clear of the MAC accumulator
//   mac_acc                      : MAC accumulator value
//   result                       : valid/ready result stream
//   busy                         : accepted start through the done cycle
//   done                         : 1-cycle pulse after the last result handshake
module conv_mac_sequencer
    import conv_mac_sequencer_pkg::*;
#(
    parameter int unsigned DataW  = DefDataW,
    parameter int unsigned AccW   = DefAccW,
    parameter int unsigned AddrW  = DefAddrW,
    parameter int unsigned TapW   = DefTapW,
    parameter int unsigned MacLat = DefMacLat
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [AddrW-1:0]   sample_base,
    input  logic [TapW-1:0]    num_taps,
    input  logic [AddrW-1:0]   num_out,
    output logic [AddrW-1:0]   sample_addr,
    input  logic [DataW-1:0]   sample_data,
    output logic [TapW-1:0]    coef_addr,
    input  logic [DataW-1:0]   coef_data,
    output logic [DataW-1:0]   mac_x,
    output logic [DataW-1:0]   mac_y,
    output logic               accum_reset,
    input  logic [AccW-1:0]    mac_acc,
    conv_mac_sequencer_if.master result,
    output logic               busy,
    output logic               done
);

    // One cycle of RAM latency, one operand register stage, then MacLat in the MAC
    localparam int unsigned DrainCyc = 2 + MacLat;
    localparam int unsigned DrainW   = (DrainCyc > 1) ? $clog2(DrainCyc) : 1;

    state_e           state_q;
    logic [DrainW-1:0] drain_q;
    logic             accum_reset_q;
    logic             result_valid_q;
    logic [AccW-1:0]  result_data_q;
    logic             busy_q;
    logic             done_q;
    logic             data_v_q;
    logic [DataW-1:0] mac_x_q;
    logic [DataW-1:0] mac_y_q;

    logic cfg_ok;
    logic accept;
    logic tap_step;
    logic out_step;
    logic last_tap;
    logic last_out;

    always_comb begin
        cfg_ok   = (num_taps != '0) && (num_out != '0);
        accept   = start && !busy_q && (state_q == StIdle) && cfg_ok;
        tap_step = (state_q == StFetch);
        out_step = (state_q == StHold) && result.ready && !last_out;
    end

    conv_mac_sequencer_addr_gen #(
        .AddrW (AddrW),
        .TapW  (TapW)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (accept),
        .base        (sample_base),
        .taps        (num_taps),
        .outs        (num_out),
        .tap_step    (tap_step),
        .out_step    (out_step),
        .sample_addr (sample_addr),
        .coef_addr   (coef_addr),
        .last_tap    (last_tap),
        .last_out    (last_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            drain_q        <= '0;
            accum_reset_q  <= 1'b1;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // busy_q is still high during the done cycle, blocking a back-to-back start
                    accum_reset_q <= 1'b1;
                    busy_q        <= 1'b0;
                    if (start && !busy_q) begin
                        if (cfg_ok) begin
                            busy_q  <= 1'b1;
                            state_q <= StClear;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StClear: begin
                    accum_reset_q <= 1'b0;
                    state_q       <= StFetch;
                end
                StFetch: begin
                    if (last_tap) begin
                        drain_q <= '0;
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (drain_q == DrainW'(DrainCyc - 1)) begin
                        result_data_q  <= mac_acc;
                        result_valid_q <= 1'b1;
                        state_q        <= StHold;
                    end else begin
                        drain_q <= drain_q + DrainW'(1);
                    end
                end
                StHold: begin
                    if (result.ready) begin
                        result_valid_q <= 1'b0;
                        accum_reset_q  <= 1'b1;
                        if (last_out) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            state_q <= StClear;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Operand pipeline: data_v_q marks the cycle RAM data for an issued tap is present
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_v_q <= 1'b0;
            mac_x_q  <= '0;
            mac_y_q  <= '0;
        end else begin
            data_v_q <= (state_q == StFetch);
            mac_x_q  <= data_v_q ? sample_data : '0;
            mac_y_q  <= data_v_q ? coef_data : '0;
        end
    end

    assign mac_x        = mac_x_q;
    assign mac_y        = mac_y_q;
    assign accum_reset  = accum_reset_q;
    assign result.data  = result_data_q;
    assign result.valid = result_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
